// File: rtl/result_buffer_4x_pkg.sv
// rtl/result_buffer_4x_pkg.sv - shared encodings for the four-bank result buffer
package result_buffer_4x_pkg;

    localparam int NUM_BANKS = 4;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_RECV  = 2'b01,
        CMD_READ  = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RECV  = 2'b01,
        ST_READ  = 2'b10,
        ST_CLEAR = 2'b11
    } state_t;

    function automatic state_t cmd_to_state(input logic [1:0] c);
        case (c)
            CMD_RECV:  return ST_RECV;
            CMD_READ:  return ST_READ;
            CMD_CLEAR: return ST_CLEAR;
            default:   return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/result_buffer_4x_bank.sv
// rtl/result_buffer_4x_bank.sv - one MMU_SIZE x MMU_SIZE bank: row write, row clear, registered element read
module result_bank #(
    parameter int VAR_SIZE = 8,
    parameter int MMU_SIZE = 10,
    parameter int IDX_W    = (MMU_SIZE > 1) ? $clog2(MMU_SIZE) : 1
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic                         clr_en,
    input  logic [IDX_W-1:0]             wr_row,
    input  logic [VAR_SIZE*MMU_SIZE-1:0] wr_data,
    input  logic                         rd_en,
    input  logic [IDX_W-1:0]             rd_row,
    input  logic [IDX_W-1:0]             rd_col,
    output logic [VAR_SIZE-1:0]          rd_data
);

    logic [VAR_SIZE-1:0] mem [MMU_SIZE][MMU_SIZE];

    // Storage carries no reset; a clear is an explicit row-by-row operation.
    always_ff @(posedge clk) begin
        if (wr_en || clr_en) begin
            for (int k = 0; k < MMU_SIZE; k++) begin
                mem[wr_row][k] <= clr_en ? '0 : wr_data[VAR_SIZE*k +: VAR_SIZE];
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_row][rd_col];
        end
    end

endmodule

// File: rtl/result_buffer_4x.sv
// rtl/result_buffer_4x.sv - four-bank MMU result buffer: row-wide receive, serial element readout
module result_buffer_4x
    import result_buffer_4x_pkg::*;
#(
    parameter int VAR_SIZE = 8,
    parameter int MMU_SIZE = 10
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic signed [VAR_SIZE*MMU_SIZE-1:0] C1,
    input  logic [1:0]                          cmd,
    input  logic [4:0]                          buffer,
    input  logic [7:0]                          dim_x_in,
    input  logic [7:0]                          dim_y_in,
    input  logic                                stop,
    output logic signed [VAR_SIZE-1:0]          D,
    output logic                                d_valid,
    output logic [7:0]                          dim_x_out,
    output logic [7:0]                          dim_y_out,
    output logic                                busy
);

    localparam int IDX_W = (MMU_SIZE > 1) ? $clog2(MMU_SIZE) : 1;
    localparam logic [7:0] MAX_DIM = 8'(MMU_SIZE);

    state_t      state;
    logic [1:0]  active;
    logic [1:0]  rd_sel;
    logic [7:0]  row_ptr;
    logic [7:0]  col_ptr;
    logic [7:0]  dim_x_r [NUM_BANKS];
    logic [7:0]  dim_y_r [NUM_BANKS];
    logic [VAR_SIZE-1:0] bank_rd [NUM_BANKS];

    logic [7:0] cur_dx;
    logic [7:0] cur_dy;
    logic       dims_zero;
    logic       wr_en;
    logic       clr_en;
    logic       issue;

    assign cur_dx    = dim_x_r[active];
    assign cur_dy    = dim_y_r[active];
    assign dims_zero = (cur_dx == 8'd0) || (cur_dy == 8'd0);
    assign wr_en     = (state == ST_RECV) && !stop && !dims_zero;
    assign clr_en    = (state == ST_CLEAR);
    assign issue     = (state == ST_READ) && !stop && !dims_zero;
    assign busy      = (state != ST_IDLE);

    // Bank read data is already registered; d_valid gates it so D idles at zero.
    assign D = d_valid ? signed'(bank_rd[rd_sel]) : '0;

    function automatic logic [7:0] clamp_dim(input logic [7:0] d);
        return (d > MAX_DIM) ? MAX_DIM : d;
    endfunction

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        result_bank #(
            .VAR_SIZE (VAR_SIZE),
            .MMU_SIZE (MMU_SIZE),
            .IDX_W    (IDX_W)
        ) u_bank (
            .clk     (clk),
            .wr_en   (wr_en && (active == 2'(b))),
            .clr_en  (clr_en && (active == 2'(b))),
            .wr_row  (row_ptr[IDX_W-1:0]),
            .wr_data (C1),
            .rd_en   (issue && (active == 2'(b))),
            .rd_row  (row_ptr[IDX_W-1:0]),
            .rd_col  (col_ptr[IDX_W-1:0]),
            .rd_data (bank_rd[b])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            active    <= 2'd0;
            rd_sel    <= 2'd0;
            row_ptr   <= 8'd0;
            col_ptr   <= 8'd0;
            d_valid   <= 1'b0;
            dim_x_out <= 8'd0;
            dim_y_out <= 8'd0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                dim_x_r[i] <= 8'd0;
                dim_y_r[i] <= 8'd0;
            end
        end else begin
            d_valid <= issue;
            rd_sel  <= active;

            if (buffer <= 5'd3) begin
                dim_x_out <= dim_x_r[buffer[1:0]];
                dim_y_out <= dim_y_r[buffer[1:0]];
            end else begin
                dim_x_out <= 8'd0;
                dim_y_out <= 8'd0;
            end

            case (state)
                ST_IDLE: begin
                    if ((cmd != CMD_NONE) && (buffer <= 5'd3)) begin
                        active  <= buffer[1:0];
                        row_ptr <= 8'd0;
                        col_ptr <= 8'd0;
                        state   <= cmd_to_state(cmd);
                        if (cmd == CMD_RECV) begin
                            dim_x_r[buffer[1:0]] <= clamp_dim(dim_x_in);
                            dim_y_r[buffer[1:0]] <= clamp_dim(dim_y_in);
                        end else if (cmd == CMD_CLEAR) begin
                            dim_x_r[buffer[1:0]] <= 8'd0;
                            dim_y_r[buffer[1:0]] <= 8'd0;
                        end
                    end
                end
                ST_RECV: begin
                    if (dims_zero) begin
                        state <= ST_IDLE;
                    end else if (!stop) begin
                        row_ptr <= row_ptr + 8'd1;
                        if (row_ptr == cur_dx - 8'd1) state <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (dims_zero) begin
                        state <= ST_IDLE;
                    end else if (!stop) begin
                        if (col_ptr == cur_dy - 8'd1) begin
                            col_ptr <= 8'd0;
                            if (row_ptr == cur_dx - 8'd1) state <= ST_IDLE;
                            else                          row_ptr <= row_ptr + 8'd1;
                        end else begin
                            col_ptr <= col_ptr + 8'd1;
                        end
                    end
                end
                ST_CLEAR: begin
                    row_ptr <= row_ptr + 8'd1;
                    if (row_ptr == MAX_DIM - 8'd1) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/result_buffer_4x.md
RESULT_BUFFER_4X -- requirements
Module: result_buffer_4x

Interface
REQ-001 The module SHALL have parameter VAR_SIZE, default 8, the element width in bits.
REQ-002 The module SHALL have parameter MMU_SIZE, default 10, the lanes per row vector and the rows per bank.
REQ-003 The module SHALL have port clk, input, 1 bit, the system clock; all state SHALL be updated on the rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit, the reset: synchronous, active-low.
REQ-005 The module SHALL have port C1, input, signed VAR_SIZE*MMU_SIZE bits, the row vector from the MMU; lane k occupies bits [VAR_SIZE*(k+1)-1 : VAR_SIZE*k].
REQ-006 The module SHALL have port cmd, input, 2 bits: 00 NONE, 01 RECV, 10 READ, 11 CLEAR.
REQ-007 The module SHALL have port buffer, input, 5 bits, the bank select; values 0-3 are valid.
REQ-008 The module SHALL have ports dim_x_in and dim_y_in, input, 8 bits each, giving the rows and columns of the incoming result.
REQ-009 The module SHALL have port stop, input, 1 bit, the stall request.
REQ-010 The module SHALL have port D, output, signed VAR_SIZE bits, the serial element output.
REQ-011 The module SHALL have port d_valid, output, 1 bit, which qualifies D.
REQ-012 The module SHALL have ports dim_x_out and dim_y_out, output, 8 bits each, giving the stored dimensions of the bank selected by buffer.
REQ-013 The module SHALL have port busy, output, 1 bit, high whenever state is not IDLE.

Function
REQ-014 The module SHALL contain four independent banks (0-3), each holding MMU_SIZE x MMU_SIZE elements plus an 8-bit dim_x and an 8-bit dim_y.
REQ-015 The module SHALL implement the state machine IDLE, RECV, READ, CLEAR.
REQ-016 In IDLE, a cmd other than NONE with buffer<=3 SHALL latch buffer[1:0] as the active bank, clear row and column pointers, and enter the state named by cmd.
REQ-017 In IDLE, cmd with buffer>3 SHALL be ignored.
REQ-018 cmd SHALL be ignored in every state other than IDLE.
REQ-019 On IDLE->RECV the active bank's dims SHALL load min(dim_x_in, MMU_SIZE) and min(dim_y_in, MMU_SIZE).
REQ-020 On IDLE->CLEAR the active bank's dims SHALL load 0.
REQ-021 In RECV, each cycle with stop=0 SHALL write the full C1 into row row_pointer of the active bank and increment row_pointer.
REQ-022 RECV SHALL return to IDLE after the write of row dim_x-1.
REQ-023 In RECV, a cycle with stop=1 SHALL perform no write and hold the pointers.
REQ-024 In READ, each cycle with stop=0 SHALL issue element [row][col] of the active bank in row-major order: col increments 0..dim_y-1, then wraps to 0 and increments row.
REQ-025 For each element issued in READ, D SHALL present that element and d_valid SHALL be 1 exactly one cycle after issue.
REQ-026 READ SHALL return to IDLE in the cycle after issuing element [dim_x-1][dim_y-1].
REQ-027 In READ, a cycle with stop=1 SHALL issue nothing and hold the pointers; d_valid SHALL be 0 in the following cycle.
REQ-028 When no element was issued in the previous cycle, d_valid SHALL be 0 and D SHALL be 0.
REQ-029 In READ, d_valid SHALL be high for exactly dim_x*dim_y cycles in total.
REQ-030 CLEAR SHALL zero rows 0..MMU_SIZE-1 of the active bank, one row per cycle, ignoring stop, then return to IDLE; it takes MMU_SIZE cycles.
REQ-031 When RECV or READ is entered with a stored dim of 0, the module SHALL spend one cycle in that state, perform no write and assert no d_valid, then return to IDLE.
REQ-032 READ SHALL use the active bank's stored dims, not dim_x_in or dim_y_in.
REQ-033 Banks other than the active bank SHALL never be modified.
REQ-034 dim_x_out and dim_y_out SHALL be registered copies of the dims of bank buffer[1:0], with one-cycle latency.
REQ-035 dim_x_out and dim_y_out SHALL read 0 when buffer>3.

Reset
REQ-036 While rst_n=0 at a clock edge, the module SHALL force state IDLE, active bank 0, pointers 0, all bank dims 0, D=0, d_valid=0, dim_x_out=0, dim_y_out=0 and busy=0.
REQ-037 Reset asserted mid-RECV, mid-READ or mid-CLEAR SHALL abort the operation immediately; bank element contents need not be cleared.

Structure
REQ-038 A shared package SHALL hold the cmd encodings, the state encodings and the bank count (4).
REQ-039 The bank storage SHALL be one sub-module, result_bank (row-wide write port, single-element registered read port, row clear), instantiated four times.

Verification
REQ-040 Reset check: hold rst_n=0 for 2 cycles, then release -> all outputs 0, busy=0, dim_x_out=dim_y_out=0 for every buffer value 0-3.
REQ-041 Basic receive and read: RECV buffer=2, dims 3x4, rows with lane k = 10*row+k, then READ buffer=2 -> D sequence 0,1,2,3,10,11,12,13,20,21,22,23 with d_valid high for 12 cycles, first valid one cycle after first issue.
REQ-042 Read stall: repeat the read with stop=1 for 2 cycles after the 5th issue -> d_valid low for 2 cycles, sequence unchanged, busy drops one cycle after the last issue.
REQ-043 Bank isolation and clear: load bank 0 with all 5 and bank 1 with all 7 (dims 2x2), then CLEAR bank 0 -> dim_x_out=0 for buffer=0, dim_x_out=2 for buffer=1; READ bank 1 returns 7,7,7,7; CLEAR takes 10 cycles.
REQ-044 Boundaries: RECV with dims 12x12 -> stored dims 10x10 and a 100-element read; READ with dims 0 -> one busy cycle and no d_valid; cmd=READ with buffer=5 -> ignored.
REQ-045 Reset mid-READ: assert rst_n=0 after the 3rd valid element -> next cycle d_valid=0 and busy=0, then a new READ starts from element [0][0].
